// File: rtl/pcoeff_result_collector.sv
// rtl/pcoeff_result_collector.sv - result FIFO, backpressure, running totals and bot tracking
module pcoeff_result_collector #(
    parameter int DEPTH           = 64,
    parameter int SLOWDOWN_MARGIN = 16,
    parameter int OUTSTANDING_W   = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     finish,
    input  logic                     botAccepted,
    input  logic                     resultValid,
    input  logic [47:0]              pcoeffSum,
    input  logic [12:0]              pcoeffCount,
    input  logic                     eccStatus,
    output logic                     slowDown,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [61:0]              outData,
    output logic [63:0]              totalSum,
    output logic [31:0]              totalCount,
    output logic [31:0]              resultIndex,
    output logic [OUTSTANDING_W-1:0] outstanding,
    output logic                     done,
    output logic                     overflowErr,
    output logic                     eccErr,
    output logic                     protocolErr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] SLOW_C = (AW+1)'(DEPTH - SLOWDOWN_MARGIN);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [OUTSTANDING_W-1:0] OUT_ONE = OUTSTANDING_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [61:0]              mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [AW:0]              count_q;
    logic                     slow_q, done_q, ovf_q, ecc_q, proto_q;
    logic [63:0]              sum_q;
    logic [31:0]              cnt_q, idx_q;
    logic [OUTSTANDING_W-1:0] outst_q;

    logic active, full, pop, res_in, bot_in, push;

    // start takes the cycle for clearing, so beats and bots arriving with it are ignored
    always_comb begin
        active = (state_q != IDLE);
        full   = (count_q == FULL_C);
        pop    = (count_q != '0) && outReady;
        res_in = resultValid && active && !start;
        bot_in = botAccepted && active && !start;
        push   = res_in && (!full || pop);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {eccStatus, pcoeffCount, pcoeffSum};
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slow_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ecc_q    <= 1'b0;
            proto_q  <= 1'b0;
            sum_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            outst_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            slow_q <= (count_q >= SLOW_C);

            if (start) begin
                state_q <= RUN;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
                ecc_q   <= 1'b0;
                proto_q <= 1'b0;
                sum_q   <= '0;
                cnt_q   <= '0;
                idx_q   <= '0;
                outst_q <= '0;
            end else begin
                if (push) begin
                    sum_q <= sum_q + {16'd0, pcoeffSum};
                    cnt_q <= cnt_q + {19'd0, pcoeffCount};
                    idx_q <= idx_q + 32'd1;
                    if (eccStatus) ecc_q <= 1'b1;
                end
                if (res_in && !push) ovf_q <= 1'b1;

                if (bot_in && !res_in) begin
                    if (outst_q == '1) proto_q <= 1'b1;
                    else               outst_q <= outst_q + OUT_ONE;
                end else if (res_in && !bot_in) begin
                    if (outst_q == '0) proto_q <= 1'b1;
                    else               outst_q <= outst_q - OUT_ONE;
                end

                if (resultValid && !active)    proto_q <= 1'b1;
                if (finish && state_q != RUN)  proto_q <= 1'b1;

                case (state_q)
                    RUN: if (finish) state_q <= DRAIN;
                    DRAIN: begin
                        if (outst_q == '0 && count_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign slowDown    = slow_q;
    assign outValid    = (count_q != '0);
    assign outData     = outValid ? mem_q[rd_ptr_q] : '0;
    assign totalSum    = sum_q;
    assign totalCount  = cnt_q;
    assign resultIndex = idx_q;
    assign outstanding = outst_q;
    assign done        = done_q;
    assign overflowErr = ovf_q;
    assign eccErr      = ecc_q;
    assign protocolErr = proto_q;
endmodule

// File: tb/tb_pcoeff_result_collector.sv
// tb/tb_pcoeff_result_collector.sv - directed vector bench for pcoeff_result_collector
module tb_pcoeff_result_collector;
    logic        clock = 1'b0;
    logic        rst, start, finish, botAccepted, resultValid, eccStatus, outReady;
    logic [47:0] pcoeffSum;
    logic [12:0] pcoeffCount;
    logic        slowDown, outValid, done, overflowErr, eccErr, protocolErr;
    logic [61:0] outData;
    logic [63:0] totalSum;
    logic [31:0] totalCount, resultIndex;
    logic [15:0] outstanding;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pcoeff_result_collector dut (
        .clock(clock), .rst(rst), .start(start), .finish(finish),
        .botAccepted(botAccepted), .resultValid(resultValid),
        .pcoeffSum(pcoeffSum), .pcoeffCount(pcoeffCount), .eccStatus(eccStatus),
        .slowDown(slowDown), .outValid(outValid), .outReady(outReady), .outData(outData),
        .totalSum(totalSum), .totalCount(totalCount), .resultIndex(resultIndex),
        .outstanding(outstanding), .done(done), .overflowErr(overflowErr),
        .eccErr(eccErr), .protocolErr(protocolErr)
    );

    typedef struct {
        logic        st, fin, bot, rv;
        logic [47:0] sum;
        logic [12:0] cnt;
        logic        ecc, rdy;
        logic        e_valid;
        logic [61:0] e_data;
        logic [63:0] e_sum;
        logic [31:0] e_cnt, e_idx;
        logic [15:0] e_out;
        logic        e_done;
        logic [2:0]  e_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic fin, input logic bot, input logic rv,
                         input logic [47:0] s, input logic [12:0] c, input logic e, input logic r);
        start = st; finish = fin; botAccepted = bot; resultValid = rv;
        pcoeffSum = s; pcoeffCount = c; eccStatus = e; outReady = r;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{1,0,0,0, 48'd0, 13'd0, 0,0, 0, 62'd0, 64'd0, 32'd0, 32'd0, 16'd0, 0, 3'b000};
        vecs[1]  = '{0,0,1,0, 48'd0, 13'd0, 0,0, 0, 62'd0, 64'd0, 32'd0, 32'd0, 16'd1, 0, 3'b000};
        vecs[2]  = '{0,0,1,0, 48'd0, 13'd0, 0,0, 0, 62'd0, 64'd0, 32'd0, 32'd0, 16'd2, 0, 3'b000};
        vecs[3]  = '{0,0,1,0, 48'd0, 13'd0, 0,0, 0, 62'd0, 64'd0, 32'd0, 32'd0, 16'd3, 0, 3'b000};
        vecs[4]  = '{0,0,0,1, 48'd5, 13'd1, 0,1, 1, {1'b0,13'd1,48'd5}, 64'd5, 32'd1, 32'd1, 16'd2, 0, 3'b000};
        vecs[5]  = '{0,0,0,1, 48'd7, 13'd2, 0,1, 1, {1'b0,13'd2,48'd7}, 64'd12, 32'd3, 32'd2, 16'd1, 0, 3'b000};
        vecs[6]  = '{0,0,0,1, 48'd11, 13'd3, 0,1, 1, {1'b0,13'd3,48'd11}, 64'd23, 32'd6, 32'd3, 16'd0, 0, 3'b000};
        vecs[7]  = '{0,0,0,0, 48'd0, 13'd0, 0,1, 0, 62'd0, 64'd23, 32'd6, 32'd3, 16'd0, 0, 3'b000};
        vecs[8]  = '{0,0,0,1, 48'd1, 13'd0, 1,1, 1, {1'b1,13'd0,48'd1}, 64'd24, 32'd6, 32'd4, 16'd0, 0, 3'b011};
        vecs[9]  = '{0,0,0,0, 48'd0, 13'd0, 0,1, 0, 62'd0, 64'd24, 32'd6, 32'd4, 16'd0, 0, 3'b011};
        vecs[10] = '{0,1,0,0, 48'd0, 13'd0, 0,0, 0, 62'd0, 64'd24, 32'd6, 32'd4, 16'd0, 0, 3'b011};
        vecs[11] = '{0,0,0,0, 48'd0, 13'd0, 0,0, 0, 62'd0, 64'd24, 32'd6, 32'd4, 16'd0, 1, 3'b011};

        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("reset outValid", 64'(outValid), 64'd0);
        check("reset outData", 64'(outData), 64'd0);
        check("reset totalSum", totalSum, 64'd0);
        check("reset flags", 64'({slowDown, done, overflowErr, eccErr, protocolErr}), 64'd0);
        check("reset outstanding", 64'(outstanding), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].st, vecs[i].fin, vecs[i].bot, vecs[i].rv,
                  vecs[i].sum, vecs[i].cnt, vecs[i].ecc, vecs[i].rdy);
            tick();
            check($sformatf("v%0d outValid", i), 64'(outValid), 64'(vecs[i].e_valid));
            check($sformatf("v%0d outData", i), 64'(outData), 64'(vecs[i].e_data));
            check($sformatf("v%0d totalSum", i), totalSum, vecs[i].e_sum);
            check($sformatf("v%0d totalCount", i), 64'(totalCount), 64'(vecs[i].e_cnt));
            check($sformatf("v%0d resultIndex", i), 64'(resultIndex), 64'(vecs[i].e_idx));
            check($sformatf("v%0d outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
            check($sformatf("v%0d done", i), 64'(done), 64'(vecs[i].e_done));
            check($sformatf("v%0d errs", i), 64'({overflowErr, eccErr, protocolErr}), 64'(vecs[i].e_err));
        end

        // fill to slowDown threshold, then full, then overflow
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0);
        tick();
        check("start clears done", 64'(done), 64'd0);
        for (int i = 1; i <= 64; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 48'(i), 13'd1, 1'b0, 1'b0);
            tick();
            if (i == 48) check("slowDown after 48th push", 64'(slowDown), 64'd0);
            if (i == 49) check("slowDown one cycle later", 64'(slowDown), 64'd1);
        end
        check("full resultIndex", 64'(resultIndex), 64'd64);
        check("full no overflow", 64'(overflowErr), 64'd0);
        check("full head", 64'(outData), 64'({1'b0, 13'd1, 48'd1}));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 48'd999, 13'd1, 1'b0, 1'b0);
        tick();
        check("drop overflowErr", 64'(overflowErr), 64'd1);
        check("drop resultIndex", 64'(resultIndex), 64'd64);
        check("drop totalSum", totalSum, 64'd2080);
        check("drop totalCount", 64'(totalCount), 64'd64);

        // FIFO stays full across start; simultaneous push and pop
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0);
        tick();
        check("start clears overflow", 64'(overflowErr), 64'd0);
        check("start clears totalSum", totalSum, 64'd0);
        check("full slowDown held", 64'(slowDown), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 48'd1000, 13'd1, 1'b0, 1'b1);
        tick();
        check("push+pop no overflow", 64'(overflowErr), 64'd0);
        check("push+pop resultIndex", 64'(resultIndex), 64'd1);
        check("push+pop totalSum", totalSum, 64'd1000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b1);
        for (int k = 0; k < 64; k++) begin
            check($sformatf("drain %0d data", k), 64'(outData),
                  64'({1'b0, 13'd1, (k < 63) ? 48'(k + 2) : 48'd1000}));
            tick();
        end
        check("drained outValid", 64'(outValid), 64'd0);

        // drain to DONE
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0); tick();
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 48'd3, 13'd1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 48'd4, 13'd1, 1'b0, 1'b0); tick();
        check("drain outstanding", 64'(outstanding), 64'd0);
        check("drain not done", 64'(done), 64'd0);
        check("drain protocolErr", 64'(protocolErr), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b1); tick();
        tick();
        idle_inputs();
        check("done after last pop edge", 64'(done), 64'd0);
        tick();
        check("done one cycle later", 64'(done), 64'd1);
        check("done totalSum", totalSum, 64'd7);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0); tick();
        check("restart clears done", 64'(done), 64'd0);
        check("restart clears totals", 64'(totalSum) | 64'(resultIndex), 64'd0);

        // reset mid-DRAIN with 10 queued
        drive(1'b0, 1'b0, 1'b1, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 48'd0, 13'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 48'd9, 13'd2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        idle_inputs();
        check("pre-reset resultIndex", 64'(resultIndex), 64'd10);
        check("pre-reset outstanding", 64'(outstanding), 64'd2);
        rst = 1'b0;
        tick();
        check("mid reset outValid", 64'(outValid), 64'd0);
        check("mid reset totals", totalSum | 64'(totalCount) | 64'(resultIndex), 64'd0);
        check("mid reset outstanding", 64'(outstanding), 64'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 48'd5, 13'd1, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check("idle result protocolErr", 64'(protocolErr), 64'd1);
        check("idle result ignored", 64'(outValid) | 64'(resultIndex), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
